regfile_param_2r1w: RTL and testbench

- Parametrised two-read, one-write register file.
- Successor to the fixed 8x8 register file, for the processor datapath.
- Adds generic width and depth, a single common clock edge, read-enable, and write-to-read bypass.
- Adds per-entry valid bits, an optional hard-wired zero register, and a sequenced clear engine.
- Sits between decode (read addresses) and writeback (write port).

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_read_port.sv | 63 ++++++
 rtl/regfile_param_2r1w.sv | 164 ++++++++++++++++
 tb/tb_regfile_param_2r1w.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised 2R1W register file.
package rf_pkg;

  // Default geometry used by the CPU top.
  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;

  // Clear engine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: address select, write bypass, zero-register
// and busy masking, then the output register.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic                                   clk,
  input  logic                                   RESET,
  input  logic                                   rd_en,
  input  logic [ADDR_W-1:0]                      rd_addr,
  input  logic                                   busy,
  input  logic                                   wr_fire,
  input  logic [ADDR_W-1:0]                      wr_addr,
  input  logic [DATA_W-1:0]                      wr_data,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]     mem,
  input  logic [(1<<ADDR_W)-1:0]                 vld,
  output logic [DATA_W-1:0]                      rd_data,
  output logic                                   rd_vld
);

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_vld_q, rd_vld_d;

  // Next read result. Priority: busy mask, zero register, bypass, storage.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_vld_d  = rd_vld_q;
    if (rd_en) begin
      if (busy) begin
        rd_data_d = '0;
        rd_vld_d  = 1'b0;
      end else if ((ZERO_REG0 != 0) && (rd_addr == '0)) begin
        rd_data_d = '0;
        rd_vld_d  = 1'b1;
      end else if ((BYPASS != 0) && wr_fire && (rd_addr == wr_addr)) begin
        rd_data_d = wr_data;
        rd_vld_d  = 1'b1;
      end else begin
        rd_data_d = mem[rd_addr];
        rd_vld_d  = vld[rd_addr];
      end
    end
  end

  // Output register; holds when rd_en is low.
  always_ff @(posedge clk) begin
    if (RESET) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_vld  = rd_vld_q;

endmodule

// File: rtl/regfile_param_2r1w.sv
// Parametrised two-read, one-write register file with per-entry valid bits,
// optional hard-wired zero register and a sequenced clear engine.
//
// Write handshake: a write is taken on a rising edge when wr_en && wr_ready;
// wr_ready is low while the clear engine runs, and the writer must hold
// wr_en/wr_addr/wr_data until it sees wr_ready high on an edge.
module regfile_param_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd1_vld,
  output logic              rd2_vld,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic [1:0]        dbg_clr_state
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_CLEAR = CLEAR;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [1:0]                   state_q, state_d;
  logic [ADDR_W-1:0]            ptr_q, ptr_d;
  logic                         busy_q, busy_d;
  logic                         clr_done_q, clr_done_d;

  logic wr_fire;
  logic wr_commit;

  // A write is accepted whenever the clear engine is idle; entry 0 is
  // read-only when the zero register is enabled.
  assign wr_fire   = wr_en && !busy_q;
  assign wr_commit = wr_fire && !((ZERO_REG0 != 0) && (wr_addr == '0));

  // Storage update: accepted write or one clear step per cycle.
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    if (wr_commit) begin
      mem_d[wr_addr] = wr_data;
      vld_d[wr_addr] = 1'b1;
    end
    if (state_q == ST_CLEAR) begin
      mem_d[ptr_q] = '0;
      vld_d[ptr_q] = 1'b0;
    end
  end

  // Clear engine: walks every entry once, then a one-cycle DONE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
    busy_d     = (state_d != ST_IDLE);
    clr_done_d = (state_d == ST_DONE);
  end

  // State registers; reset wins over everything and aborts a clear.
  always_ff @(posedge clk) begin
    if (RESET) begin
      mem_q      <= '0;
      vld_q      <= '0;
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      vld_q      <= vld_d;
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  rf_read_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BYPASS    (BYPASS),
    .ZERO_REG0 (ZERO_REG0)
  ) u_rd1 (
    .clk     (clk),
    .RESET   (RESET),
    .rd_en   (rd_en),
    .rd_addr (rd1_addr),
    .busy    (busy_q),
    .wr_fire (wr_fire),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .mem     (mem_q),
    .vld     (vld_q),
    .rd_data (rd1_data),
    .rd_vld  (rd1_vld)
  );

  rf_read_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BYPASS    (BYPASS),
    .ZERO_REG0 (ZERO_REG0)
  ) u_rd2 (
    .clk     (clk),
    .RESET   (RESET),
    .rd_en   (rd_en),
    .rd_addr (rd2_addr),
    .busy    (busy_q),
    .wr_fire (wr_fire),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .mem     (mem_q),
    .vld     (vld_q),
    .rd_data (rd2_data),
    .rd_vld  (rd2_vld)
  );

  assign wr_ready      = !busy_q;
  assign busy          = busy_q;
  assign clr_done      = clr_done_q;
  assign dbg_clr_state = state_q;

endmodule

// File: tb/tb_regfile_param_2r1w.sv
// Bench for regfile_param_2r1w: default build plus BYPASS=0 and ZERO_REG0=1
// builds driven from the same stimulus.
module tb_regfile_param_2r1w;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RESET = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [2:0] rd1_addr = '0;
  logic [2:0] rd2_addr = '0;
  logic       clr_req = 1'b0;

  logic [7:0] d_rd1_data, d_rd2_data, n_rd1_data, n_rd2_data, z_rd1_data, z_rd2_data;
  logic       d_rd1_vld, d_rd2_vld, n_rd1_vld, n_rd2_vld, z_rd1_vld, z_rd2_vld;
  logic       d_wr_ready, n_wr_ready, z_wr_ready;
  logic       d_busy, n_busy, z_busy;
  logic       d_clr_done, n_clr_done, z_clr_done;
  logic [1:0] d_st, n_st, z_st;

  regfile_param_2r1w u_dut (
    .clk(clk), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(d_wr_ready), .rd_en(rd_en), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(d_rd1_data), .rd2_data(d_rd2_data), .rd1_vld(d_rd1_vld), .rd2_vld(d_rd2_vld),
    .clr_req(clr_req), .busy(d_busy), .clr_done(d_clr_done), .dbg_clr_state(d_st)
  );

  regfile_param_2r1w #(.BYPASS(0)) u_nb (
    .clk(clk), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(n_wr_ready), .rd_en(rd_en), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(n_rd1_data), .rd2_data(n_rd2_data), .rd1_vld(n_rd1_vld), .rd2_vld(n_rd2_vld),
    .clr_req(clr_req), .busy(n_busy), .clr_done(n_clr_done), .dbg_clr_state(n_st)
  );

  regfile_param_2r1w #(.ZERO_REG0(1)) u_z (
    .clk(clk), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(z_wr_ready), .rd_en(rd_en), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(z_rd1_data), .rd2_data(z_rd2_data), .rd1_vld(z_rd1_vld), .rd2_vld(z_rd2_vld),
    .clr_req(clr_req), .busy(z_busy), .clr_done(z_clr_done), .dbg_clr_state(z_st)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] d1;
    logic       v1;
    logic [7:0] d2;
    logic       v2;
    logic [7:0] nb1;
    logic [7:0] z1d;
    logic       z1v;
    logic       busy;
    logic       done;
    logic       rdy;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [2:0] a1;
    logic [2:0] a2;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic exp_t mk_e(logic [7:0] d1, logic v1, logic [7:0] d2, logic v2,
                                logic [7:0] nb1, logic [7:0] z1d, logic z1v,
                                logic busy, logic done, logic rdy, logic [1:0] st);
    exp_t e;
    e.d1 = d1; e.v1 = v1; e.d2 = d2; e.v2 = v2; e.nb1 = nb1;
    e.z1d = z1d; e.z1v = z1v; e.busy = busy; e.done = done; e.rdy = rdy; e.st = st;
    return e;
  endfunction

  // Idle-state expectation with only read results varying.
  function automatic exp_t mk_i(logic [7:0] d1, logic v1, logic [7:0] d2, logic v2,
                                logic [7:0] nb1, logic [7:0] z1d, logic z1v);
    return mk_e(d1, v1, d2, v2, nb1, z1d, z1v, 1'b0, 1'b0, 1'b1, 2'd0);
  endfunction

  function automatic vec_t mk_v(logic we, logic [2:0] wa, logic [7:0] wd, logic re,
                                logic [2:0] a1, logic [2:0] a2, exp_t e);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.a1 = a1; v.a2 = a2; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " exp_q_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, " rd1_data"}, 32'(d_rd1_data), 32'(e.d1));
    chk({tag, " rd1_vld"},  32'(d_rd1_vld),  32'(e.v1));
    chk({tag, " rd2_data"}, 32'(d_rd2_data), 32'(e.d2));
    chk({tag, " rd2_vld"},  32'(d_rd2_vld),  32'(e.v2));
    chk({tag, " nb_rd1_data"}, 32'(n_rd1_data), 32'(e.nb1));
    chk({tag, " z_rd1_data"},  32'(z_rd1_data), 32'(e.z1d));
    chk({tag, " z_rd1_vld"},   32'(z_rd1_vld),  32'(e.z1v));
    chk({tag, " busy"},     32'(d_busy),     32'(e.busy));
    chk({tag, " clr_done"}, 32'(d_clr_done), 32'(e.done));
    chk({tag, " wr_ready"}, 32'(d_wr_ready), 32'(e.rdy));
    chk({tag, " state"},    32'(d_st),       32'(e.st));
    chk({tag, " nb_busy"},  32'(n_busy),     32'(e.busy));
    chk({tag, " z_done"},   32'(z_clr_done), 32'(e.done));
  endtask

  // ---------------- driver ----------------
  task automatic run_cycle(input logic rst, input logic we, input logic [2:0] wa,
                           input logic [7:0] wd, input logic re, input logic [2:0] a1,
                           input logic [2:0] a2, input logic clr, input exp_t e,
                           input string tag);
    @(negedge clk);
    RESET = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd1_addr = a1; rd2_addr = a2; clr_req = clr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  // Read every entry in pairs; all must be cleared.
  task automatic read_all_cleared(input string tag);
    for (int i = 0; i < 4; i++) begin
      logic [2:0] a1;
      logic [2:0] a2;
      a1 = 3'(2 * i);
      a2 = 3'(2 * i + 1);
      run_cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, a1, a2, 1'b0,
                mk_i(8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, (a1 == 3'd0)),
                $sformatf("%s_pair%0d", tag, i));
    end
  endtask

  vec_t vecs[11];

  // ---------------- test ----------------
  initial begin
    // {we, wa, wd, re, a1, a2, expected {dut rd1/rd2, bypass-off rd1, zero-reg rd1}}
    vecs[0]  = mk_v(0, 3'd0, 8'd0,   1, 3'd0, 3'd1, mk_i(8'd0,   0, 8'd0,   0, 8'd0,   8'd0,  1));
    vecs[1]  = mk_v(1, 3'd2, 8'd200, 0, 3'd0, 3'd0, mk_i(8'd0,   0, 8'd0,   0, 8'd0,   8'd0,  1));
    vecs[2]  = mk_v(1, 3'd4, 8'd100, 0, 3'd0, 3'd0, mk_i(8'd0,   0, 8'd0,   0, 8'd0,   8'd0,  1));
    vecs[3]  = mk_v(0, 3'd0, 8'd0,   1, 3'd2, 3'd4, mk_i(8'd200, 1, 8'd100, 1, 8'd200, 8'd200, 1));
    vecs[4]  = mk_v(0, 3'd0, 8'd0,   1, 3'd5, 3'd2, mk_i(8'd0,   0, 8'd200, 1, 8'd0,   8'd0,  0));
    vecs[5]  = mk_v(1, 3'd2, 8'd33,  1, 3'd2, 3'd2, mk_i(8'd33,  1, 8'd33,  1, 8'd200, 8'd33, 1));
    vecs[6]  = mk_v(0, 3'd0, 8'd0,   1, 3'd2, 3'd4, mk_i(8'd33,  1, 8'd100, 1, 8'd33,  8'd33, 1));
    vecs[7]  = mk_v(1, 3'd0, 8'hFF,  0, 3'd0, 3'd0, mk_i(8'd33,  1, 8'd100, 1, 8'd33,  8'd33, 1));
    vecs[8]  = mk_v(0, 3'd0, 8'd0,   1, 3'd0, 3'd0, mk_i(8'hFF,  1, 8'hFF,  1, 8'hFF,  8'd0,  1));
    vecs[9]  = mk_v(1, 3'd0, 8'h11,  1, 3'd0, 3'd7, mk_i(8'h11,  1, 8'd0,   0, 8'hFF,  8'd0,  1));
    vecs[10] = mk_v(0, 3'd0, 8'd0,   0, 3'd3, 3'd3, mk_i(8'h11,  1, 8'd0,   0, 8'hFF,  8'd0,  1));

    // Reset state.
    for (int i = 0; i < 2; i++)
      run_cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 1'b0,
                mk_i(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0), $sformatf("reset%0d", i));

    // Table-driven write / read / bypass / zero-register vectors.
    for (int i = 0; i < 11; i++)
      run_cycle(1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].a1,
                vecs[i].a2, 1'b0, vecs[i].e, $sformatf("vec%0d", i));

    // One-cycle reset wipes written entries.
    run_cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 1'b0,
              mk_i(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0), "rst_pulse");
    run_cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd2, 3'd4, 1'b0,
              mk_i(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0), "post_rst_read");

    // Full sequenced clear.
    run_cycle(1'b0, 1'b1, 3'd1, 8'd7, 1'b0, 3'd0, 3'd0, 1'b0,
              mk_i(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0), "clr_pre_wr1");
    run_cycle(1'b0, 1'b1, 3'd6, 8'd9, 1'b0, 3'd0, 3'd0, 1'b0,
              mk_i(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0), "clr_pre_wr6");
    run_cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd1, 3'd6, 1'b0,
              mk_i(8'd7, 1, 8'd9, 1, 8'd7, 8'd7, 1), "clr_pre_rd");
    // clr_req together with a write: write accepted, busy rises on this edge.
    run_cycle(1'b0, 1'b1, 3'd5, 8'h77, 1'b1, 3'd1, 3'd6, 1'b1,
              mk_e(8'd7, 1, 8'd9, 1, 8'd7, 8'd7, 1, 1'b1, 1'b0, 1'b0, 2'd1), "clr_start");
    // Eight clear cycles with a held write and reads that must be masked.
    for (int k = 1; k <= 8; k++)
      run_cycle(1'b0, 1'b1, 3'd3, 8'h5A, 1'b1, 3'd1, 3'd6, 1'b0,
                mk_e(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0, 1'b1, (k == 8),
                     1'b0, (k == 8) ? 2'd2 : 2'd1),
                $sformatf("clr_busy%0d", k));
    // DONE edge: write still dropped, read still masked, busy falls.
    run_cycle(1'b0, 1'b1, 3'd3, 8'h5A, 1'b1, 3'd1, 3'd6, 1'b0,
              mk_i(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0), "clr_end");
    read_all_cleared("clr_after");

    // Reset in the fourth clear cycle aborts without clr_done.
    run_cycle(1'b0, 1'b1, 3'd2, 8'h42, 1'b0, 3'd0, 3'd0, 1'b0,
              mk_i(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0), "abort_wr");
    run_cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 1'b1,
              mk_e(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0, 1'b1, 1'b0, 1'b0, 2'd1), "abort_start");
    for (int k = 1; k <= 3; k++)
      run_cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 1'b0,
                mk_e(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0, 1'b1, 1'b0, 1'b0, 2'd1),
                $sformatf("abort_clr%0d", k));
    run_cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 1'b0,
              mk_i(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0), "abort_rst");
    for (int k = 0; k < 12; k++)
      run_cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 1'b0,
                mk_i(8'd0, 0, 8'd0, 0, 8'd0, 8'd0, 0), $sformatf("abort_idle%0d", k));
    read_all_cleared("abort_after");

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
